// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves data-memory waits, branch/jump mispredicts detected in MEM and
// load-use hazards between ID and EX. It drives every pipeline register
// enable and flush, the fetch redirect and the predictor update port. It also
// keeps saturating stall/flush counters and a sticky memory-timeout flag.
//
// Memory handshake: dmem_req is held high for as long as the instruction in
// MEM is a load or store. The access completes in the cycle dmem_ready is
// high. Until then the EX/MEM contents, and therefore dmem_req, are held
// stable by the frozen pipeline.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memRead,
    input  logic             ex_mem_branch,
    input  logic             ex_mem_jump,
    input  logic             ex_mem_zero,
    input  logic             ex_mem_prediction,
    input  logic             ex_mem_memRead,
    input  logic             ex_mem_memWrite,
    input  logic [31:0]      ex_mem_PC,
    input  logic [31:0]      ex_mem_PC_plus_X,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             bp_upd_valid,
    output logic             bp_upd_taken,
    output logic [31:0]      bp_upd_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic             dbg_state
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic mem_access;
    logic taken;
    logic mispredict;
    logic load_use;
    logic mem_wait;
    logic any_en_low;

    // Hazard event decode from the current pipeline register contents.
    always_comb begin
        mem_access = ex_mem_memRead | ex_mem_memWrite;
        taken      = ex_mem_jump | (ex_mem_branch & ex_mem_zero);
        mispredict = (ex_mem_branch | ex_mem_jump) & (taken != ex_mem_prediction);
        load_use   = id_ex_memRead & (id_ex_rd != 5'd0) &
                     ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
        mem_wait   = rst_n & (((state_q == ST_RUN) & mem_access & ~dmem_ready) |
                              ((state_q == ST_MEM_WAIT) & ~dmem_ready));
    end

    // Next state and pipeline controls: memory wait beats mispredict beats load-use.
    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = taken ? ex_mem_PC_plus_X : (ex_mem_PC + 32'd4);
        bp_upd_valid = ex_mem_branch & ~mem_wait;
        bp_upd_taken = taken;
        bp_upd_pc    = ex_mem_PC;
        dmem_req     = mem_access;
        if (!rst_n) begin
            state_d      = ST_RUN;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            redirect_pc  = 32'd0;
            bp_upd_valid = 1'b0;
            bp_upd_taken = 1'b0;
            bp_upd_pc    = 32'd0;
            dmem_req     = 1'b0;
        end else if (mem_wait) begin
            // Whole pipeline frozen; the branch update is deferred until release.
            state_d   = ST_MEM_WAIT;
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else begin
            state_d = ST_RUN;
            if (mispredict) begin
                redirect     = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Performance counters, wait counter and sticky timeout next-state.
    always_comb begin
        any_en_low    = ~(pc_en & if_id_en & id_ex_en & ex_mem_en & mem_wb_en);
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        if (any_en_low && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (state_d == ST_RUN) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_MEM_WAIT && wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if (state_d == ST_MEM_WAIT && wait_cnt_d == WAIT_MAX) begin
            mem_timeout_d = 1'b1;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// hand-written multi-cycle sequences and randomized traffic checked against
// a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
    logic             id_ex_memRead;
    logic             ex_mem_branch, ex_mem_jump, ex_mem_zero, ex_mem_prediction;
    logic             ex_mem_memRead, ex_mem_memWrite;
    logic [31:0]      ex_mem_PC, ex_mem_PC_plus_X;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             bp_upd_valid, bp_upd_taken;
    logic [31:0]      bp_upd_pc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;
    logic             dbg_state;

    logic [4:0] en_bus;
    logic [2:0] fl_bus;
    assign en_bus = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl_bus = {if_id_flush, id_ex_flush, ex_mem_flush};

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_memRead(id_ex_memRead),
        .ex_mem_branch(ex_mem_branch), .ex_mem_jump(ex_mem_jump),
        .ex_mem_zero(ex_mem_zero), .ex_mem_prediction(ex_mem_prediction),
        .ex_mem_memRead(ex_mem_memRead), .ex_mem_memWrite(ex_mem_memWrite),
        .ex_mem_PC(ex_mem_PC), .ex_mem_PC_plus_X(ex_mem_PC_plus_X),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .bp_upd_valid(bp_upd_valid), .bp_upd_taken(bp_upd_taken), .bp_upd_pc(bp_upd_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout(mem_timeout), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [4:0]  e_en;
    logic [2:0]  e_fl;
    logic        e_redir, e_bpv, e_bpt, e_req;
    logic [31:0] e_rpc, e_bppc;
    logic        m_freeze;
    int          m_stall, m_flush, m_run;
    logic        m_to;
    logic        hold;

    // Rule-level model of the combinational controls for the current inputs.
    task automatic model_eval();
        logic tk, misp, lu, macc;
        tk   = ex_mem_jump | (ex_mem_branch & ex_mem_zero);
        misp = (ex_mem_branch | ex_mem_jump) && (tk != ex_mem_prediction);
        lu   = id_ex_memRead && id_ex_rd != 0 && (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
        macc = ex_mem_memRead | ex_mem_memWrite;
        m_freeze = rst_n && macc && !dmem_ready;
        e_en = 5'b11111; e_fl = 3'b000; e_redir = 0;
        e_rpc = tk ? ex_mem_PC_plus_X : ex_mem_PC + 32'd4;
        e_bpv = ex_mem_branch; e_bpt = tk; e_bppc = ex_mem_PC; e_req = macc;
        if (!rst_n) begin
            e_en = 0; e_rpc = 0; e_bpv = 0; e_bpt = 0; e_bppc = 0; e_req = 0;
        end else if (m_freeze) begin
            e_en = 0; e_bpv = 0;
        end else if (misp) begin
            e_fl = 3'b111; e_redir = 1;
        end else if (lu) begin
            e_en = 5'b00111; e_fl = 3'b010;
        end
    endtask

    task automatic comb_phase();
        #4;
        model_eval();
        chk("en", en_bus, e_en);
        chk("flush", fl_bus, e_fl);
        chk("redirect", redirect, e_redir);
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("bp_valid", bp_upd_valid, e_bpv);
        chk("bp_taken", bp_upd_taken, e_bpt);
        chk("bp_pc", bp_upd_pc, e_bppc);
        chk("dmem_req", dmem_req, e_req);
    endtask

    task automatic clock_phase();
        if (!rst_n) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
        end else begin
            if (e_en != 5'b11111 && m_stall < CNT_SAT) m_stall++;
            if (e_redir && m_flush < CNT_SAT) m_flush++;
            // First frozen cycle is in RUN; timeout counts the waiting cycles after it.
            m_run = m_freeze ? m_run + 1 : 0;
            if (m_run >= TIMEOUT + 1) m_to = 1;
        end
        hold = m_freeze;
        @(posedge clk);
        #1;
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("mem_timeout", mem_timeout, m_to);
    endtask

    task automatic step();
        comb_phase();
        clock_phase();
    endtask

    task automatic set_idle();
        rst_n = 1; if_id_rs1 = 1; if_id_rs2 = 2; id_ex_rd = 3; id_ex_memRead = 0;
        ex_mem_branch = 0; ex_mem_jump = 0; ex_mem_zero = 0; ex_mem_prediction = 0;
        ex_mem_memRead = 0; ex_mem_memWrite = 0; ex_mem_PC = 32'h1000;
        ex_mem_PC_plus_X = 32'h2000; dmem_ready = 1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        memrd, br, jmp, zero, pred, mr, mw, rdy;
        logic [31:0] pc, pcx;
        logic [4:0]  en;
        logic [2:0]  fl;
        logic        redir;
        logic [31:0] rpc;
        logic        bpv, bpt, req;
    } vec_t;

    function automatic vec_t mkv(input logic [4:0] rs1, rs2, rd,
                                 input logic memrd, br, jmp, zero, pred, mr, mw, rdy,
                                 input logic [31:0] pc, pcx,
                                 input logic [4:0] en, input logic [2:0] fl,
                                 input logic redir, input logic [31:0] rpc,
                                 input logic bpv, bpt, req);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.memrd = memrd; v.br = br; v.jmp = jmp;
        v.zero = zero; v.pred = pred; v.mr = mr; v.mw = mw; v.rdy = rdy; v.pc = pc;
        v.pcx = pcx; v.en = en; v.fl = fl; v.redir = redir; v.rpc = rpc;
        v.bpv = bpv; v.bpt = bpt; v.req = req;
        return v;
    endfunction

    vec_t vt[14];

    initial begin
        // Directed single-cycle vectors, all applied in RUN.
        vt[0]  = mkv(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 32'h20, 5'h1f, 3'b000, 0, 32'h0, 0, 0, 0);
        vt[1]  = mkv(5, 9, 5, 1, 0, 0, 0, 0, 0, 0, 1, 32'h20, 32'h40, 5'b00111, 3'b010, 0, 32'h0, 0, 0, 0);
        vt[2]  = mkv(9, 7, 7, 1, 0, 0, 0, 0, 0, 0, 1, 32'h24, 32'h40, 5'b00111, 3'b010, 0, 32'h0, 0, 0, 0);
        vt[3]  = mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h28, 32'h40, 5'h1f, 3'b000, 0, 32'h0, 0, 0, 0);
        vt[4]  = mkv(5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2c, 32'h40, 5'h1f, 3'b000, 0, 32'h0, 0, 0, 0);
        vt[5]  = mkv(1, 2, 3, 0, 1, 0, 1, 0, 0, 0, 1, 32'h100, 32'h140, 5'h1f, 3'b111, 1, 32'h140, 1, 1, 0);
        vt[6]  = mkv(1, 2, 3, 0, 1, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFC, 32'h40, 5'h1f, 3'b111, 1, 32'h0, 1, 0, 0);
        vt[7]  = mkv(1, 2, 3, 0, 1, 0, 1, 1, 0, 0, 1, 32'h80, 32'hC0, 5'h1f, 3'b000, 0, 32'h0, 1, 1, 0);
        vt[8]  = mkv(1, 2, 3, 0, 0, 1, 0, 0, 0, 0, 1, 32'h200, 32'h300, 5'h1f, 3'b111, 1, 32'h300, 0, 1, 0);
        vt[9]  = mkv(1, 2, 3, 0, 0, 1, 1, 1, 0, 0, 1, 32'h204, 32'h300, 5'h1f, 3'b000, 0, 32'h0, 0, 1, 0);
        vt[10] = mkv(4, 8, 4, 1, 1, 0, 1, 0, 0, 0, 1, 32'h300, 32'h380, 5'h1f, 3'b111, 1, 32'h380, 1, 1, 0);
        vt[11] = mkv(1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 1, 32'h400, 32'h0, 5'h1f, 3'b000, 0, 32'h0, 0, 0, 1);
        vt[12] = mkv(6, 2, 6, 1, 0, 0, 0, 0, 0, 1, 1, 32'h404, 32'h0, 5'b00111, 3'b010, 0, 32'h0, 0, 0, 1);
        vt[13] = mkv(1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 1, 32'h500, 32'h600, 5'h1f, 3'b000, 0, 32'h0, 1, 0, 0);

        m_stall = 0; m_flush = 0; m_run = 0; m_to = 0; hold = 0;

        // Reset state
        do_reset();
        chk("reset_state", dbg_state, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if_id_rs1 = vt[i].rs1; if_id_rs2 = vt[i].rs2; id_ex_rd = vt[i].rd;
            id_ex_memRead = vt[i].memrd; ex_mem_branch = vt[i].br; ex_mem_jump = vt[i].jmp;
            ex_mem_zero = vt[i].zero; ex_mem_prediction = vt[i].pred;
            ex_mem_memRead = vt[i].mr; ex_mem_memWrite = vt[i].mw; dmem_ready = vt[i].rdy;
            ex_mem_PC = vt[i].pc; ex_mem_PC_plus_X = vt[i].pcx;
            comb_phase();
            chk($sformatf("vec%0d_en", i), en_bus, vt[i].en);
            chk($sformatf("vec%0d_flush", i), fl_bus, vt[i].fl);
            chk($sformatf("vec%0d_redirect", i), redirect, vt[i].redir);
            if (vt[i].redir) chk($sformatf("vec%0d_rpc", i), redirect_pc, vt[i].rpc);
            chk($sformatf("vec%0d_bpv", i), bp_upd_valid, vt[i].bpv);
            chk($sformatf("vec%0d_bpt", i), bp_upd_taken, vt[i].bpt);
            chk($sformatf("vec%0d_req", i), dmem_req, vt[i].req);
            clock_phase();
        end

        // Three-cycle memory wait
        do_reset();
        set_idle(); ex_mem_memRead = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            comb_phase();
            chk("memwait_en", en_bus, 5'b00000);
            clock_phase();
            chk("memwait_state", dbg_state, 1'b1);
        end
        chk("memwait_stall3", stall_cnt, 3);
        dmem_ready = 1;
        comb_phase();
        chk("memwait_release_en", en_bus, 5'b11111);
        clock_phase();
        chk("memwait_back_run", dbg_state, 1'b0);
        chk("memwait_stall_final", stall_cnt, 3);
        set_idle();
        step();

        // Load-use during a memory wait: freeze only, then a single bubble
        set_idle(); id_ex_memRead = 1; id_ex_rd = 5; if_id_rs1 = 5;
        ex_mem_memRead = 1; dmem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            comb_phase();
            chk("lu_wait_flush", fl_bus, 3'b000);
            clock_phase();
        end
        dmem_ready = 1;
        comb_phase();
        chk("lu_after_wait_en", en_bus, 5'b00111);
        chk("lu_after_wait_fl", fl_bus, 3'b010);
        clock_phase();
        set_idle();
        comb_phase();
        chk("lu_resolved_en", en_bus, 5'b11111);
        clock_phase();

        // Timeout with dmem_ready held low, then reset mid-wait
        do_reset();
        set_idle(); ex_mem_memWrite = 1; dmem_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("timeout_c%0d", i), mem_timeout, (i >= TIMEOUT + 1));
        end
        dmem_ready = 1;
        step();
        chk("timeout_sticky", mem_timeout, 1'b1);
        chk("timeout_run", dbg_state, 1'b0);
        dmem_ready = 0;
        step();
        step();
        chk("rst_mid_prewait", dbg_state, 1'b1);
        rst_n = 0;
        comb_phase();
        chk("rst_en", en_bus, 5'b00000);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_bppc", bp_upd_pc, 32'h0);
        clock_phase();
        chk("rst_state", dbg_state, 1'b0);
        chk("rst_stall0", stall_cnt, 0);
        chk("rst_timeout0", mem_timeout, 1'b0);
        set_idle(); dmem_ready = 0;
        comb_phase();
        chk("rst_abandon_en", en_bus, 5'b11111);
        clock_phase();

        // Single mispredict increments flush_cnt once
        do_reset();
        set_idle(); ex_mem_branch = 1; ex_mem_zero = 1; ex_mem_PC = 32'h100; ex_mem_PC_plus_X = 32'h140;
        step();
        set_idle();
        step();
        chk("flush_cnt_one", flush_cnt, 1);

        // Counter saturation
        do_reset();
        set_idle(); id_ex_memRead = 1; id_ex_rd = 9; if_id_rs2 = 9;
        for (int i = 0; i < CNT_SAT + 5; i++) step();
        chk("stall_sat", stall_cnt, CNT_SAT);
        set_idle(); ex_mem_jump = 1; ex_mem_prediction = 0;
        for (int i = 0; i < CNT_SAT + 5; i++) step();
        chk("flush_sat", flush_cnt, CNT_SAT);

        // Randomized traffic; EX/MEM held while an access is outstanding
        do_reset();
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if_id_rs1 = 5'($urandom_range(0, 3));
            if_id_rs2 = 5'($urandom_range(0, 3));
            id_ex_rd  = 5'($urandom_range(0, 3));
            id_ex_memRead = ($urandom_range(0, 1) == 1);
            if (hold) begin
                dmem_ready = ($urandom_range(0, 2) == 0);
            end else begin
                int r, m;
                r = $urandom_range(0, 3);
                m = $urandom_range(0, 3);
                ex_mem_branch = (r == 0);
                ex_mem_jump   = (r == 1);
                ex_mem_zero   = ($urandom_range(0, 1) == 1);
                ex_mem_prediction = ($urandom_range(0, 1) == 1);
                ex_mem_memRead  = (m == 0);
                ex_mem_memWrite = (m == 1);
                ex_mem_PC = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : {$urandom} & 32'hFFFFFFFC;
                ex_mem_PC_plus_X = $urandom;
                dmem_ready = ($urandom_range(0, 1) == 1);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
